fixed_to_floating_conversion: RTL
=================================

Name: fixed_to_floating_conversion

Overview:
- Converts an unsigned Q(INTEGER).(FRACTION) fixed-point word into an IEEE-754 single-precision value.
- Sits at the output of the fixed-point exponential/softmax datapath and hands results back to the floating-point domain.
- It is the inverse of the float-to-fixed converter at the datapath input.
- Normalisation is iterative: one left shift per clock until the leading one reaches the MSB. Latency therefore varies with input magnitude.

Parameters:
- DATA_WIDTH, 32, width of fixed input and float output.
- M, 23, mantissa width.
- E, 8, exponent width.
- bias, (2**(E-1))-1 = 127, exponent bias.
- INTEGER, 10, integer bits of the fixed input.
- FRACTION, 22, fraction bits of the fixed input. INTEGER+FRACTION = DATA_WIDTH.
- CNT_W, 5, width of the shift counter, clog2(DATA_WIDTH).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- fixed_point_input  input  DATA_WIDTH  unsigned fixed-point operand. Sampled only in IDLE when start is high.
- start_fixed_to_floating_conversion  input  1  start request. Ignored when not in IDLE.
- floating_point_output  output  DATA_WIDTH  registered result {sign, exponent, mantissa}. Sign is always 0.
- floating_point_number_ready  output  1  one-cycle pulse; floating_point_output is valid in that cycle.
- busy  output  1  high in every state except IDLE.

Behaviour:
- Reset (reset low, asynchronous):
  - state goes to IDLE.
  - floating_point_output = 0, floating_point_number_ready = 0, busy = 0.
  - Shift register and counter are cleared.
- FSM states: IDLE, NORMALIZE, PACK, DONE.
  - IDLE: if start is high, load shift_reg <= fixed_point_input, cnt <= 0, go to NORMALIZE. Otherwise stay.
  - NORMALIZE:
    - If shift_reg == 0, set zero_flag and go to PACK.
    - Else if shift_reg[DATA_WIDTH-1] == 1, go to PACK.
    - Else shift_reg <= shift_reg << 1, cnt <= cnt + 1, stay.
  - PACK: register floating_point_output, go to DONE.
  - DONE: floating_point_number_ready = 1, go to IDLE.
- Arithmetic, with s = final cnt (0..DATA_WIDTH-1):
  - Leading-one position p = DATA_WIDTH-1-s.
  - Biased exponent = p - FRACTION + bias, computed E+1 bits wide. Range for defaults is 105..136, so underflow and overflow are impossible.
  - Mantissa = shift_reg[DATA_WIDTH-2 : DATA_WIDTH-1-M] (hidden one dropped). When p < M, lower bits are the zeros shifted in.
  - Default rounding is truncation (toward zero).
  - zero_flag forces output 32'h00000000.
- Latency: ready is high in cycle s+3 after the edge that sampled start. Minimum 3 (MSB set, or zero input); maximum DATA_WIDTH+2 = 34.
- floating_point_output holds its value until the next PACK. It is not cleared when a new conversion starts.
- Start asserted while busy is dropped, with no queueing.
- Start held high continuously: a new conversion begins in the IDLE cycle after DONE. There is no back-to-back overlap.
- Reset mid-conversion aborts immediately. No ready pulse is produced, and the output returns to 0.

Optional Feature:
- Macro: FIXED_TO_FLOAT_ROUND_NEAREST_EN
- Defined: PACK applies round-to-nearest-even.
  - Guard bit = shift_reg[DATA_WIDTH-2-M]; sticky = OR of the bits below the guard bit.
  - Increment when guard & (sticky | mantissa LSB).
  - Mantissa carry-out clears the mantissa and increments the exponent. Latency is unchanged.
- Undefined: truncation only; no rounding logic is present.

Test Plan:
- 32'h00400000 (1.0), start pulse -> floating_point_output 32'h3F800000, ready 12 cycles after start (s=9).
- 32'h00C00000 (3.0), then 32'h00200000 (0.5) issued after ready -> 32'h40400000, then 32'h3F000000. The ready pulse is exactly one cycle each time.
- 32'h00000000 -> 32'h00000000 with latency 3. 32'h00000001 -> 32'h34800000 with latency 34 (maximum).
- 32'hFFFFFFFF -> 32'h447FFFFF without the macro. With FIXED_TO_FLOAT_ROUND_NEAREST_EN -> 32'h44800000 (mantissa carry into exponent). Also 32'h80000001 with the macro -> 32'h44000000 (guard 0, no round-up).
- Start re-pulsed during NORMALIZE of 32'h00000001 -> ignored: single result 32'h34800000, busy high throughout, one ready pulse.
- reset driven low during NORMALIZE -> output 0, busy 0, no ready. After release, 32'h00400000 converts normally to 32'h3F800000.

Source files
------------

// File: rtl/fixed_to_floating_conversion_if.sv
// Handshake bundle between the fixed-point datapath and the fixed-to-float converter.
// The master drives the operand and start; the slave returns the packed float, ready and busy.
interface fixed_to_floating_conversion_if #(
   parameter int DATA_WIDTH = 32
);
   logic [DATA_WIDTH-1:0] fixed_point_input;
   logic                  start_fixed_to_floating_conversion;
   logic [DATA_WIDTH-1:0] floating_point_output;
   logic                  floating_point_number_ready;
   logic                  busy;

   modport master (
      output fixed_point_input,
      output start_fixed_to_floating_conversion,
      input  floating_point_output,
      input  floating_point_number_ready,
      input  busy
   );

   modport slave (
      input  fixed_point_input,
      input  start_fixed_to_floating_conversion,
      output floating_point_output,
      output floating_point_number_ready,
      output busy
   );
endinterface

// File: rtl/fixed_to_floating_conversion.sv
// Unsigned Q(INTEGER).(FRACTION) to IEEE-754 single, one normalising shift per clock.
// FIXED_TO_FLOAT_ROUND_NEAREST_EN selects round-to-nearest-even in PACK; default truncates.
module fixed_to_floating_conversion #(
   parameter int DATA_WIDTH = 32,
   parameter int M          = 23,
   parameter int E          = 8,
   parameter int BIAS       = (2**(E-1))-1,
   parameter int INTEGER    = 10,
   parameter int FRACTION   = 22,
   parameter int CNT_W      = $clog2(DATA_WIDTH)
) (
   input  logic                          clk,
   input  logic                          reset,
   fixed_to_floating_conversion_if.slave bus
);

   if (INTEGER + FRACTION != DATA_WIDTH) begin : g_bad_format
      $error("INTEGER + FRACTION must equal DATA_WIDTH");
   end

   typedef enum logic [1:0] {
      S_IDLE,
      S_NORMALIZE,
      S_PACK,
      S_DONE
   } state_t;

   // Exponent of a leading one at the MSB; each shift lowers it by one.
   localparam logic [E:0] EXP_BASE = (E+1)'(DATA_WIDTH - 1 - FRACTION + BIAS);

   state_t                r_state;
   state_t                w_next_state;
   logic [DATA_WIDTH-1:0] r_shift_reg;
   logic [CNT_W-1:0]      r_cnt;
   logic                  r_zero_flag;
   logic [DATA_WIDTH-1:0] r_float;
   logic                  r_ready;

   logic                  w_is_zero;
   logic                  w_msb_set;
   logic [E:0]            w_exponent;
   logic [M-1:0]          w_mantissa;
   logic [E:0]            w_exp_final;
   logic [M-1:0]          w_mant_final;
   logic [DATA_WIDTH-1:0] w_packed;

   assign w_is_zero  = (r_shift_reg == '0);
   assign w_msb_set  = r_shift_reg[DATA_WIDTH-1];
   assign w_exponent = EXP_BASE - {{(E+1-CNT_W){1'b0}}, r_cnt};
   assign w_mantissa = r_shift_reg[DATA_WIDTH-2 -: M];

`ifdef FIXED_TO_FLOAT_ROUND_NEAREST_EN
   logic       w_guard;
   logic       w_sticky;
   logic       w_round_up;
   logic [M:0] w_mant_sum;

   assign w_guard      = r_shift_reg[DATA_WIDTH-2-M];
   assign w_sticky     = |r_shift_reg[DATA_WIDTH-3-M:0];
   assign w_round_up   = w_guard & (w_sticky | w_mantissa[0]);
   assign w_mant_sum   = {1'b0, w_mantissa} + {{M{1'b0}}, w_round_up};
   // A carry out of the mantissa leaves it all-zero and bumps the exponent.
   assign w_mant_final = w_mant_sum[M-1:0];
   assign w_exp_final  = w_exponent + {{E{1'b0}}, w_mant_sum[M]};
`else
   assign w_mant_final = w_mantissa;
   assign w_exp_final  = w_exponent;
`endif

   assign w_packed = {1'b0, w_exp_final[E-1:0], w_mant_final};

   a_exp_in_range: assert property (@(posedge clk) disable iff (!reset)
      (r_state == S_PACK) |-> !w_exp_final[E]);

   // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // NOTE: next state defaults to the current state first, so no path infers a latch.
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         S_IDLE: begin
            if (bus.start_fixed_to_floating_conversion) begin
               w_next_state = S_NORMALIZE;
            end
         end
         S_NORMALIZE: begin
            if (w_is_zero || w_msb_set) begin
               w_next_state = S_PACK;
            end
         end
         S_PACK:  w_next_state = S_DONE;
         S_DONE:  w_next_state = S_IDLE;
         default: w_next_state = S_IDLE;
      endcase
   end

   // NOTE: every datapath register is reset, so an abort leaves no stale operand or result.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_shift_reg <= '0;
         r_cnt       <= '0;
         r_zero_flag <= 1'b0;
         r_float     <= '0;
         r_ready     <= 1'b0;
      end else begin
         r_ready <= (r_state == S_DONE);
         case (r_state)
            S_IDLE: begin
               if (bus.start_fixed_to_floating_conversion) begin
                  r_shift_reg <= bus.fixed_point_input;
                  r_cnt       <= '0;
                  r_zero_flag <= 1'b0;
               end
            end
            S_NORMALIZE: begin
               if (w_is_zero) begin
                  r_zero_flag <= 1'b1;
               end else if (!w_msb_set) begin
                  r_shift_reg <= r_shift_reg << 1;
                  r_cnt       <= r_cnt + 1'b1;
               end
            end
            S_PACK: begin
               r_float <= r_zero_flag ? '0 : w_packed;
            end
            default: ;
         endcase
      end
   end

   assign bus.floating_point_output       = r_float;
   assign bus.floating_point_number_ready = r_ready;
   assign bus.busy                        = (r_state != S_IDLE);

endmodule
